// File: rtl/seq_parser_mc.sv
// ----------------------------------------------------------------------------
// seq_parser_mc
//
// Multi-stream packet parser. Consumes a 32-bit word stream of packets, each
// made of an 8-byte header (length, stream id, sequence number) followed by a
// payload. A per-stream expected-sequence table is kept. Malformed, stale and
// unknown-stream packets are dropped, and sequence gaps are flagged. One
// assembled packet at a time is presented on the output side.
//
// Handshake semantics (both sides): a word/packet transfers on a rising clk
// edge where valid and ready are both high. A source holds valid and its data
// stable until that transfer. The input side never depends on dataIn_val to
// raise dataIn_ready.
//
// Ports
//   clk, reset_b        clock (rising edge), asynchronous active-low reset
//   dataIn[31:0]        input word, byte 0 in [31:24] ... byte 3 in [7:0]
//   dataIn_val/_ready   input handshake
//   dataIn_last         final word of a packet
//   dataOut[0:PW-1]     payload, byte k in bits [8k:8k+7], unused bytes zero
//   dataOut_stream      stream id of the presented packet
//   dataOut_seq         sequence number of the presented packet
//   dataOut_len         payload byte count
//   dataOut_val/_ready  output handshake
//   packetLost          presented packet followed a sequence gap
//   lostCount           saturating total of missing sequence numbers
//   dropCount           saturating total of discarded packets
//
// The FSM state is held in `state` (type stateT) for external checkers.
// ----------------------------------------------------------------------------
module seq_parser_mc #(
    parameter int NUM_STREAMS = 16,
    parameter int MAX_PAYLOAD = 37,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [31:0]              dataIn,
    input  logic                     dataIn_val,
    output logic                     dataIn_ready,
    input  logic                     dataIn_last,
    output logic [0:MAX_PAYLOAD*8-1] dataOut,
    output logic [15:0]              dataOut_stream,
    output logic [31:0]              dataOut_seq,
    output logic [15:0]              dataOut_len,
    output logic                     dataOut_val,
    input  logic                     dataOut_ready,
    output logic                     packetLost,
    output logic [CNT_W-1:0]         lostCount,
    output logic [CNT_W-1:0]         dropCount
);

    localparam int PW    = MAX_PAYLOAD * 8;
    localparam int IDX_W = $clog2(NUM_STREAMS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        SEQ   = 3'd1,
        PAY   = 3'd2,
        FLUSH = 3'd3,
        OUT   = 3'd4
    } stateT;

    stateT             state;
    stateT             nextState;

    logic [15:0]       lenReg;
    logic [15:0]       idReg;
    logic [31:0]       seqReg;
    logic              bad;
    logic [15:0]       beat;      // beats of the current packet accepted so far
    logic [15:0]       byteCnt;   // payload bytes written into asm so far
    logic [0:PW-1]     asm;       // payload assembly register
    logic [31:0]       expTab [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] tabValid;

    logic              inAcc;
    logic [15:0]       hdrLen;
    logic [15:0]       hdrId;
    logic [31:0]       wordSeq;
    logic              hdrBad;
    logic [15:0]       beats;
    logic [15:0]       payLen;
    logic [15:0]       curBeat;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       decSeq;
    logic [31:0]       delta;
    logic              decAccept;
    logic              decLost;
    logic [32:0]       lostSum;
    logic [0:PW-1]     asmNext;
    logic              doDrop;
    logic              doDecide;

    always_comb begin
        inAcc   = dataIn_val && dataIn_ready;
        hdrLen  = {dataIn[23:16], dataIn[31:24]};
        hdrId   = {dataIn[7:0], dataIn[15:8]};
        wordSeq = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
        hdrBad  = dataIn_last || (hdrLen < 16'd8) ||
                  (int'(hdrLen) > MAX_PAYLOAD + 8) ||
                  (int'(hdrId) >= NUM_STREAMS);
        beats   = 16'((32'(lenReg) + 32'd3) >> 2);
        payLen  = lenReg - 16'd8;
        curBeat = beat + 16'd1;

        // A two-beat packet decides in SEQ, so the sequence number is still
        // on the input bus rather than in seqReg.
        idx       = idReg[IDX_W-1:0];
        decSeq    = (state == SEQ) ? wordSeq : seqReg;
        delta     = decSeq - expTab[idx];
        decAccept = !tabValid[idx] || !delta[31];
        decLost   = tabValid[idx] && (delta != 32'd0) && !delta[31];
        lostSum   = 33'(lostCount) + 33'(delta);

        // Place the current word's bytes at byteCnt..byteCnt+3, skipping any
        // bytes of the final beat that lie beyond the payload length.
        asmNext = asm;
        if (state == PAY && !bad) begin
            for (int j = 0; j < MAX_PAYLOAD; j++) begin
                for (int k = 0; k < 4; k++) begin
                    if ((int'(byteCnt) + k == j) && (j < int'(payLen))) begin
                        asmNext[8*j +: 8] = dataIn[31-8*k -: 8];
                    end
                end
            end
        end

        nextState = state;
        doDrop    = 1'b0;
        doDecide  = 1'b0;
        case (state)
            HDR: if (inAcc) begin
                nextState = dataIn_last ? HDR : SEQ;
                doDrop    = dataIn_last;
            end
            SEQ: if (inAcc) begin
                if (bad) begin
                    nextState = dataIn_last ? HDR : PAY;
                    doDrop    = dataIn_last;
                end else if (dataIn_last) begin
                    if (beats == 16'd2) begin
                        doDecide = 1'b1;
                    end else begin
                        nextState = HDR;
                        doDrop    = 1'b1;
                    end
                end else if (beats == 16'd2) begin
                    nextState = FLUSH;
                    doDrop    = 1'b1;
                end else begin
                    nextState = PAY;
                end
            end
            PAY: if (inAcc) begin
                if (bad) begin
                    if (dataIn_last) begin
                        nextState = HDR;
                        doDrop    = 1'b1;
                    end
                end else if (curBeat == beats) begin
                    if (dataIn_last) begin
                        doDecide = 1'b1;
                    end else begin
                        nextState = FLUSH;
                        doDrop    = 1'b1;
                    end
                end else if (dataIn_last) begin
                    nextState = HDR;
                    doDrop    = 1'b1;
                end
            end
            FLUSH: if (inAcc && dataIn_last) nextState = HDR;
            OUT:   if (dataOut_ready) nextState = HDR;
            default: nextState = HDR;
        endcase

        // Stale or duplicate sequence numbers are dropped at the decision.
        if (doDecide) begin
            nextState = decAccept ? OUT : HDR;
            doDrop    = !decAccept;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state          <= HDR;
            lenReg         <= '0;
            idReg          <= '0;
            seqReg         <= '0;
            bad            <= 1'b0;
            beat           <= '0;
            byteCnt        <= '0;
            asm            <= '0;
            tabValid       <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) expTab[i] <= '0;
            dataIn_ready   <= 1'b0;
            dataOut        <= '0;
            dataOut_stream <= '0;
            dataOut_seq    <= '0;
            dataOut_len    <= '0;
            dataOut_val    <= 1'b0;
            packetLost     <= 1'b0;
            lostCount      <= '0;
            dropCount      <= '0;
        end else begin
            state        <= nextState;
            dataIn_ready <= (nextState != OUT);

            if (doDrop && dropCount != CNT_MAX) dropCount <= dropCount + 1'b1;

            if (inAcc) begin
                case (state)
                    HDR: begin
                        lenReg  <= hdrLen;
                        idReg   <= hdrId;
                        bad     <= hdrBad;
                        asm     <= '0;
                        byteCnt <= '0;
                        beat    <= 16'd1;
                    end
                    SEQ: begin
                        seqReg <= wordSeq;
                        beat   <= 16'd2;
                    end
                    PAY: if (!bad) begin
                        asm     <= asmNext;
                        byteCnt <= byteCnt + 16'd4;
                        beat    <= curBeat;
                    end
                    default: ;
                endcase
            end

            if (doDecide && decAccept) begin
                expTab[idx]    <= decSeq + 32'd1;
                tabValid[idx]  <= 1'b1;
                dataOut        <= asmNext;
                dataOut_stream <= idReg;
                dataOut_seq    <= decSeq;
                dataOut_len    <= payLen;
                dataOut_val    <= 1'b1;
                packetLost     <= decLost;
                if (decLost) begin
                    if (lostSum > 33'(CNT_MAX)) lostCount <= CNT_MAX;
                    else                        lostCount <= lostSum[CNT_W-1:0];
                end
            end

            if (state == OUT && dataOut_ready) begin
                dataOut_val <= 1'b0;
                packetLost  <= 1'b0;
                asm         <= '0;
            end
        end
    end

endmodule
